// File: rtl/uart_core.sv
// uart_core: independent UART receiver and transmitter with parameterised framing.
// RX samples a two-flop-synchronised line at mid-bit; TX drives a registered line.
//   state     | meaning
//   RX_IDLE   | waiting for a synchronised low
//   RX_START  | half-bit wait, then start-bit confirm or glitch reject
//   RX_DATA   | mid-bit sampling of data bits, LSB first
//   RX_PARITY | mid-bit sample of the parity bit
//   RX_STOP   | mid-bit sampling of stop bits, result published on the last one
//   RX_BREAK  | line held low past the stop bit, waiting for it to go high
//   TX_IDLE   | line high, tx_ready asserted
//   TX_START  | start bit
//   TX_DATA   | data bits, LSB first
//   TX_PARITY | parity bit
//   TX_STOP   | stop bits
module uart_core #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 921600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy,
  output logic                 tx_busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int BW  = 4;
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DIV < 8) begin : g_chk_div
    $error("uart_core: CLK_HZ/BAUD must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_core: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_core: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // ---------------- receiver ----------------
  logic rx_meta, rx_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t            rx_state, rx_state_d;
  logic [CW-1:0]        rx_cnt, rx_cnt_d;
  logic [BW-1:0]        rx_bits, rx_bits_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_par, rx_par_d;
  logic                 rx_ferr, rx_ferr_d;
  logic                 rx_valid_d, parity_err_d, frame_err_d;
  logic                 rx_par_calc, stop_ferr;

  assign rx_par_calc = (PARITY == 2) ? ~(^rx_shift) : ^rx_shift;
  assign stop_ferr   = rx_ferr | ~rx_sync;
  assign rx_busy     = (rx_state != RX_IDLE);

  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    rx_bits_d    = rx_bits;
    rx_shift_d   = rx_shift;
    rx_par_d     = rx_par;
    rx_ferr_d    = rx_ferr;
    rx_data_d    = rx_data;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
          rx_bits_d  = '0;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - CW'(1);
        end else if (rx_sync) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = DIV_M1;
          rx_ferr_d  = 1'b0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - CW'(1);
        end else begin
          rx_cnt_d   = DIV_M1;
          rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_bits == DATA_LAST) begin
            rx_bits_d  = '0;
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bits_d = rx_bits + BW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - CW'(1);
        end else begin
          rx_par_d   = rx_sync;
          rx_cnt_d   = DIV_M1;
          rx_bits_d  = '0;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - CW'(1);
        end else if (rx_bits == STOP_LAST) begin
          rx_valid_d   = 1'b1;
          rx_data_d    = rx_shift;
          parity_err_d = (PARITY != 0) && (rx_par != rx_par_calc);
          frame_err_d  = stop_ferr;
          rx_state_d   = rx_sync ? RX_IDLE : RX_BREAK;
        end else begin
          rx_bits_d = rx_bits + BW'(1);
          rx_ferr_d = stop_ferr;
          rx_cnt_d  = DIV_M1;
        end
      end
      RX_BREAK: begin
        if (rx_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bits    <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bits    <= rx_bits_d;
      rx_shift   <= rx_shift_d;
      rx_par     <= rx_par_d;
      rx_ferr    <= rx_ferr_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_d;
  logic [CW-1:0]        tx_cnt, tx_cnt_d;
  logic [BW-1:0]        tx_bits, tx_bits_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                 tx_par, tx_par_d;
  logic                 tx_d;

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx_busy  = ~tx_ready;

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bits_d  = tx_bits;
    tx_shift_d = tx_shift;
    tx_par_d   = tx_par;
    tx_d       = tx;
    case (tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (PARITY == 2) ? ~(^tx_data) : ^tx_data;
          tx_d       = 1'b0;
          tx_cnt_d   = DIV_M1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt != '0) begin
          tx_cnt_d = tx_cnt - CW'(1);
        end else begin
          tx_d       = tx_shift[0];
          tx_shift_d = {1'b0, tx_shift[DATA_BITS-1:1]};
          tx_bits_d  = '0;
          tx_cnt_d   = DIV_M1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) begin
          tx_cnt_d = tx_cnt - CW'(1);
        end else begin
          tx_cnt_d = DIV_M1;
          if (tx_bits == DATA_LAST) begin
            tx_bits_d = '0;
            if (PARITY != 0) begin
              tx_d       = tx_par;
              tx_state_d = TX_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_bits_d  = tx_bits + BW'(1);
            tx_d       = tx_shift[0];
            tx_shift_d = {1'b0, tx_shift[DATA_BITS-1:1]};
          end
        end
      end
      TX_PARITY: begin
        if (tx_cnt != '0) begin
          tx_cnt_d = tx_cnt - CW'(1);
        end else begin
          tx_d       = 1'b1;
          tx_bits_d  = '0;
          tx_cnt_d   = DIV_M1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        // Leaving on the terminal count lets a transfer in the idle cycle start immediately.
        if (tx_cnt != '0) begin
          tx_cnt_d = tx_cnt - CW'(1);
        end else if (tx_bits == STOP_LAST) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_bits_d = tx_bits + BW'(1);
          tx_cnt_d  = DIV_M1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bits  <= tx_bits_d;
      tx_shift <= tx_shift_d;
      tx_par   <= tx_par_d;
      tx       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed and randomized checks of uart_core in 8N1, 8E1 and 8O1 framings.
// Expected frames and receive results are computed from the framing rules in the bench.
module tb_uart_core;

  localparam int DIV = 50000000 / 921600;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  logic       rx_n = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] tx_data_s = 8'h00;
  logic [2:0] txv = 3'b000;

  wire [2:0] txs, rdys, busys, rxb, rxv, perrs, ferrs;
  wire [7:0] rxd_n, rxd_e, rxd_o;

  uart_core #(.CLK_HZ(50000000), .BAUD(921600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .reset(reset), .rx(rx_n), .tx(txs[0]), .tx_data(tx_data_s), .tx_valid(txv[0]),
    .tx_ready(rdys[0]), .rx_data(rxd_n), .rx_valid(rxv[0]), .parity_err(perrs[0]),
    .frame_err(ferrs[0]), .rx_busy(rxb[0]), .tx_busy(busys[0]));

  uart_core #(.CLK_HZ(50000000), .BAUD(921600), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
    .clk(clk), .reset(reset), .rx(rx_p), .tx(txs[1]), .tx_data(tx_data_s), .tx_valid(txv[1]),
    .tx_ready(rdys[1]), .rx_data(rxd_e), .rx_valid(rxv[1]), .parity_err(perrs[1]),
    .frame_err(ferrs[1]), .rx_busy(rxb[1]), .tx_busy(busys[1]));

  uart_core #(.CLK_HZ(50000000), .BAUD(921600), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_o (
    .clk(clk), .reset(reset), .rx(rx_p), .tx(txs[2]), .tx_data(tx_data_s), .tx_valid(txv[2]),
    .tx_ready(rdys[2]), .rx_data(rxd_o), .rx_valid(rxv[2]), .parity_err(perrs[2]),
    .frame_err(ferrs[2]), .rx_busy(rxb[2]), .tx_busy(busys[2]));

  int vectors = 0;
  int miscompares = 0;

  // Every received word as {frame_err, parity_err, data}, one entry per rx_valid cycle.
  logic [9:0] q_n[$];
  logic [9:0] q_e[$];
  logic [9:0] q_o[$];

  always @(negedge clk) begin
    if (rxv[0]) q_n.push_back({ferrs[0], perrs[0], rxd_n});
    if (rxv[1]) q_e.push_back({ferrs[1], perrs[1], rxd_e});
    if (rxv[2]) q_o.push_back({ferrs[2], perrs[2], rxd_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int par_mode(input int sel);
    return sel;
  endfunction

  // Parity bit a correct transmitter sends for this word in the given mode.
  function automatic logic par_bit(input int mode, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return (mode == 2) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // Line levels of one frame in transmission order; returns the number of bits.
  function automatic int make_frame(input int mode, input logic [7:0] d, input logic pb,
                                    input logic stop, output logic [15:0] f);
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    n = 9;
    if (mode != 0) begin
      f[n] = pb;
      n++;
    end
    f[n] = stop;
    return n + 1;
  endfunction

  // Called on a negedge with the selected transmitter idle; returns on the first idle negedge.
  task automatic tx_frame(input int sel, input logic [7:0] d);
    logic [15:0] f;
    int n, bad, rlow, bbad;
    n = make_frame(par_mode(sel), d, par_bit(par_mode(sel), d), 1'b1, f);
    chk($sformatf("tx%0d ready before transfer", sel), rdys[sel], 1);
    chk($sformatf("tx%0d idle level", sel), txs[sel], 1);
    tx_data_s = d;
    txv[sel] = 1'b1;
    @(negedge clk);
    txv[sel] = 1'b0;
    bad = 0; rlow = 0; bbad = 0;
    for (int i = 0; i < n * DIV; i++) begin
      if (txs[sel] !== f[i / DIV]) bad++;
      if (rdys[sel] !== 1'b1) rlow++;
      if (busys[sel] !== ~rdys[sel]) bbad++;
      tx_data_s = 8'($urandom);
      txv[sel] = 1'($urandom);
      @(negedge clk);
    end
    txv[sel] = 1'b0;
    chk($sformatf("tx%0d data %02h waveform deviating cycles", sel, d), bad, 0);
    chk($sformatf("tx%0d tx_ready low cycles", sel), rlow, n * DIV);
    chk($sformatf("tx%0d tx_busy vs tx_ready", sel), bbad, 0);
    chk($sformatf("tx%0d ready after stop", sel), rdys[sel], 1);
  endtask

  task automatic rx_send(input int line, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (line == 0) rx_n = f[i];
      else rx_p = f[i];
      repeat (DIV) @(negedge clk);
    end
    if (line == 0) rx_n = 1'b1;
    else rx_p = 1'b1;
  endtask

  task automatic rx_expect(input int sel, input logic [7:0] d, input logic pe, input logic fe);
    logic [9:0] got;
    logic [7:0] hold;
    int sz;
    got = '0;
    case (sel)
      0: begin sz = q_n.size(); if (sz > 0) got = q_n.pop_front(); q_n.delete(); hold = rxd_n; end
      1: begin sz = q_e.size(); if (sz > 0) got = q_e.pop_front(); q_e.delete(); hold = rxd_e; end
      default: begin sz = q_o.size(); if (sz > 0) got = q_o.pop_front(); q_o.delete(); hold = rxd_o; end
    endcase
    chk($sformatf("rx%0d rx_valid pulses", sel), sz, 1);
    chk($sformatf("rx%0d rx_data", sel), got[7:0], d);
    chk($sformatf("rx%0d parity_err", sel), got[8], pe);
    chk($sformatf("rx%0d frame_err", sel), got[9], fe);
    chk($sformatf("rx%0d rx_data held", sel), hold, d);
  endtask

  task automatic chk_reset_state(input string when);
    chk({when, " tx"}, txs, 3'b111);
    chk({when, " tx_ready"}, rdys, 3'b111);
    chk({when, " tx_busy"}, busys, 3'b000);
    chk({when, " rx_busy"}, rxb, 3'b000);
    chk({when, " rx_valid"}, rxv, 3'b000);
    chk({when, " rx_data"}, rxd_n, 8'h00);
    chk({when, " parity_err"}, perrs, 3'b000);
    chk({when, " frame_err"}, ferrs, 3'b000);
  endtask

  initial begin
    logic [15:0] f;
    int n, found;
    logic [7:0] d;
    logic pb, stp;

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Transmit: the reference word, random words (two back to back), and parity framings.
    tx_frame(0, 8'hA5);
    repeat (5) @(negedge clk);
    tx_frame(0, 8'($urandom));
    tx_frame(0, 8'($urandom));
    repeat (3) @(negedge clk);
    tx_frame(1, 8'($urandom));
    tx_frame(2, 8'($urandom));

    // 0x3C with parity bit 0 is correct for even and wrong for odd.
    n = make_frame(1, 8'h3C, 1'b0, 1'b1, f);
    rx_send(1, f, n);
    repeat (8) @(negedge clk);
    rx_expect(1, 8'h3C, 1'b0, 1'b0);
    rx_expect(2, 8'h3C, 1'b1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      pb = 1'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      n = make_frame(1, d, pb, stp, f);
      rx_send(1, f, n);
      repeat (8) @(negedge clk);
      rx_expect(1, d, pb != par_bit(1, d), !stp);
      rx_expect(2, d, pb != par_bit(2, d), !stp);
    end

    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      n = make_frame(0, d, 1'b0, stp, f);
      rx_send(0, f, n);
      repeat (8) @(negedge clk);
      rx_expect(0, d, 1'b0, !stp);
    end

    // Short low pulse must be rejected.
    rx_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch rx_busy asserted", rxb[0], 1);
    repeat (5) @(negedge clk);
    rx_n = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (rxb[0] == 1'b0) found = 1;
    end
    chk("glitch rx_busy cleared within 30 cycles", found, 1);
    repeat (12 * DIV) @(negedge clk);
    chk("glitch rx_valid count", q_n.size(), 0);

    // Break: one errored all-zero word, then silence until the line recovers.
    rx_n = 1'b0;
    repeat (20 * DIV) @(negedge clk);
    rx_expect(0, 8'h00, 1'b0, 1'b1);
    chk("break rx_busy held", rxb[0], 1);
    rx_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("break rx_busy released", rxb[0], 0);
    chk("break no further rx_valid", q_n.size(), 0);
    d = 8'($urandom);
    n = make_frame(0, d, 1'b0, 1'b1, f);
    rx_send(0, f, n);
    repeat (8) @(negedge clk);
    rx_expect(0, d, 1'b0, 1'b0);

    // Simultaneous transmit and receive on one instance.
    n = make_frame(0, 8'hF0, 1'b0, 1'b1, f);
    fork
      tx_frame(0, 8'h55);
      rx_send(0, f, n);
    join
    repeat (8) @(negedge clk);
    rx_expect(0, 8'hF0, 1'b0, 1'b0);

    // Reset during TX data phase with an RX frame in flight.
    tx_data_s = 8'h33;
    txv[0] = 1'b1;
    rx_n = 1'b0;
    @(negedge clk);
    txv[0] = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    chk("mid-frame tx_busy", busys[0], 1);
    chk("mid-frame rx_busy", rxb[0], 1);
    reset = 1'b0;
    #1;
    chk_reset_state("async reset");
    rx_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_state("reset held");
    reset = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    chk("aborted frame rx_valid count", q_n.size(), 0);
    chk("post-reset rx_busy", rxb[0], 0);
    d = 8'($urandom);
    n = make_frame(0, d, 1'b0, 1'b1, f);
    rx_send(0, f, n);
    repeat (8) @(negedge clk);
    rx_expect(0, d, 1'b0, 1'b0);
    tx_frame(0, 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
